// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit buffer
package uart_pkg;

  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_BYTE_W        = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - power-of-two byte FIFO with wrap-bit pointers and drop-on-full
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             push;
  logic             pop;

  // Full is judged on pre-edge pointers, so a push while full is dropped
  // even when a pop lands on the same edge.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign drop    = wr_en && full;
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte buffer plus drain FSM feeding a serial transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_TX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  tx_state_t  state;
  tx_state_t  state_next;
  logic       pop;
  logic       drop;
  logic [7:0] rd_data;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .drop    (drop)
  );

  // The !tx_busy guard in IDLE also covers a reset mid-frame: the
  // transmitter keeps running, so no strobe until it finishes.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= (state_next == START);
      if (pop) begin
        tx_data <= rd_data;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
